// File: rtl/fifo_stim_gen_if.sv
// FIFO-side bundle of the single-step stimulus generator.
// master: drives wr_clk/rd_clk/data_in/enables, samples f_full/f_empty.
interface fifo_stim_gen_if #(
    parameter int DATA_W = 3
);
    logic              wr_clk;
    logic              rd_clk;
    logic [DATA_W-1:0] data_in;
    logic              enable_wr;
    logic              enable_rd;
    logic              f_full;
    logic              f_empty;

    modport master (
        output wr_clk, rd_clk, data_in,
        output enable_wr, enable_rd,
        input  f_full, f_empty
    );

    modport slave (
        input  wr_clk, rd_clk, data_in,
        input  enable_wr, enable_rd,
        output f_full, f_empty
    );
endinterface

// File: rtl/fifo_stim_gen.sv
// fifo_stim_gen: pushbutton-driven single-step FIFO write/read pulser.
// Ports: clk_in, reset_in (async low), btn_wr/btn_rd raw buttons,
// fifo (master: clocks, data, enables, full/empty), busy, drop.
module fifo_stim_gen #(
    parameter int DEB_CYCLES   = 500000,
    parameter int PULSE_CYCLES = 4,
    parameter int DATA_W       = 3
) (
    input  logic           clk_in,
    input  logic           reset_in,
    input  logic           btn_wr,
    input  logic           btn_rd,
    fifo_stim_gen_if.master fifo,
    output logic           busy,
    output logic           drop
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [PW-1:0] P_LAST   = PW'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE_HI,
        PULSE_LO
    } state_t;

    // bit 0 = write channel, bit 1 = read channel
    logic [3:0]        meta_q, sync_q;
    logic [1:0]        btn_s;
    logic              full_s, empty_s;
    logic [1:0]        stab_q, stab_d, rise_d;
    logic [CW-1:0]     deb_q [2];
    logic [CW-1:0]     deb_d [2];
    logic [1:0]        pend_q;
    state_t            state_q;
    logic [PW-1:0]     pcnt_q;
    logic              op_rd_q;
    logic [DATA_W-1:0] seq_q;
    logic              wr_clk_q, rd_clk_q;
    logic              en_wr_q, en_rd_q;
    logic              busy_q, drop_q;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= {fifo.f_empty, fifo.f_full, btn_rd, btn_wr};
            sync_q <= meta_q;
        end
    end

    assign btn_s   = sync_q[1:0];
    assign full_s  = sync_q[2];
    assign empty_s = sync_q[3];

    // Stable state flips on the DEB_CYCLES-th consecutive differing cycle.
    always_comb begin
        stab_d = stab_q;
        deb_d[0] = '0;
        deb_d[1] = '0;
        for (int i = 0; i < 2; i++) begin
            if (btn_s[i] != stab_q[i]) begin
                if (deb_q[i] == DEB_LAST) begin
                    stab_d[i] = btn_s[i];
                end else begin
                    deb_d[i] = deb_q[i] + 1'b1;
                end
            end
        end
        rise_d = stab_d & ~stab_q;
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            stab_q <= '0;
            deb_q[0] <= '0;
            deb_q[1] <= '0;
        end else begin
            stab_q <= stab_d;
            deb_q[0] <= deb_d[0];
            deb_q[1] <= deb_d[1];
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            pcnt_q   <= '0;
            op_rd_q  <= 1'b0;
            seq_q    <= '0;
            wr_clk_q <= 1'b0;
            rd_clk_q <= 1'b0;
            en_wr_q  <= 1'b0;
            en_rd_q  <= 1'b0;
            busy_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            // Setting an already-set flag is a no-op: extra presses ignored.
            pend_q <= pend_q | rise_d;
            unique case (state_q)
                IDLE: begin
                    if (pend_q[0]) begin
                        pend_q[0] <= 1'b0;
                        if (full_s) begin
                            drop_q <= 1'b1;
                        end else begin
                            state_q <= SETUP;
                            op_rd_q <= 1'b0;
                            en_wr_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end else if (pend_q[1]) begin
                        pend_q[1] <= 1'b0;
                        if (empty_s) begin
                            drop_q <= 1'b1;
                        end else begin
                            state_q <= SETUP;
                            op_rd_q <= 1'b1;
                            en_rd_q <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    state_q <= PULSE_HI;
                    pcnt_q  <= '0;
                    if (op_rd_q) rd_clk_q <= 1'b1;
                    else         wr_clk_q <= 1'b1;
                end
                PULSE_HI: begin
                    if (pcnt_q == P_LAST) begin
                        state_q  <= PULSE_LO;
                        pcnt_q   <= '0;
                        wr_clk_q <= 1'b0;
                        rd_clk_q <= 1'b0;
                    end else begin
                        pcnt_q <= pcnt_q + 1'b1;
                    end
                end
                PULSE_LO: begin
                    if (pcnt_q == P_LAST) begin
                        state_q <= IDLE;
                        en_wr_q <= 1'b0;
                        en_rd_q <= 1'b0;
                        busy_q  <= 1'b0;
                        if (!op_rd_q) seq_q <= seq_q + 1'b1;
                    end else begin
                        pcnt_q <= pcnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // seq_q only moves on write completion, so data is steady per operation.
    assign fifo.data_in   = seq_q;
    assign fifo.wr_clk    = wr_clk_q;
    assign fifo.rd_clk    = rd_clk_q;
    assign fifo.enable_wr = en_wr_q;
    assign fifo.enable_rd = en_rd_q;
    assign busy           = busy_q;
    assign drop           = drop_q;

endmodule

// File: tb/tb_fifo_stim_gen.sv
// Bench for fifo_stim_gen with DEB_CYCLES=4, PULSE_CYCLES=2, DATA_W=3.
// Directed scenarios followed by randomized button/flag operations.
module tb_fifo_stim_gen;

    logic clk_in = 1'b0;
    logic reset_in;
    logic btn_wr, btn_rd;
    logic busy, drop;

    fifo_stim_gen_if #(.DATA_W(3)) fif ();

    fifo_stim_gen #(
        .DEB_CYCLES  (4),
        .PULSE_CYCLES(2),
        .DATA_W      (3)
    ) dut (
        .clk_in  (clk_in),
        .reset_in(reset_in),
        .btn_wr  (btn_wr),
        .btn_rd  (btn_rd),
        .fifo    (fif.master),
        .busy    (busy),
        .drop    (drop)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;

    // Observation statistics gathered on the falling edge.
    int wr_pulses = 0, rd_pulses = 0, drops = 0, busy_cyc = 0;
    int overlap = 0, bad_clk = 0, data_chg = 0;
    int wr_hi = 0, rd_hi = 0, enw_len = 0, enr_len = 0;
    int last_wr_hi = 0, last_rd_hi = 0, last_enw = 0, last_enr = 0;
    int last_wr_data = 0;
    time wr_rise_t = 0, rd_rise_t = 0;
    logic p_wr = 0, p_rd = 0, p_enw = 0;
    logic [2:0] p_data = 0;

    always @(negedge clk_in) begin
        if (fif.wr_clk && !p_wr) begin
            wr_pulses++;
            last_wr_data = int'(fif.data_in);
            wr_rise_t = $time;
        end
        if (fif.rd_clk && !p_rd) begin
            rd_pulses++;
            rd_rise_t = $time;
        end
        if (fif.wr_clk) wr_hi++;
        else if (wr_hi != 0) begin last_wr_hi = wr_hi; wr_hi = 0; end
        if (fif.rd_clk) rd_hi++;
        else if (rd_hi != 0) begin last_rd_hi = rd_hi; rd_hi = 0; end
        if (fif.enable_wr) enw_len++;
        else if (enw_len != 0) begin last_enw = enw_len; enw_len = 0; end
        if (fif.enable_rd) enr_len++;
        else if (enr_len != 0) begin last_enr = enr_len; enr_len = 0; end
        if (fif.enable_wr && fif.enable_rd) overlap++;
        if ((fif.wr_clk && !fif.enable_wr) || (fif.rd_clk && !fif.enable_rd))
            bad_clk++;
        if (fif.enable_wr && p_enw && fif.data_in !== p_data) data_chg++;
        if (drop) drops++;
        if (busy) busy_cyc++;
        p_wr = fif.wr_clk;
        p_rd = fif.rd_clk;
        p_enw = fif.enable_wr;
        p_data = fif.data_in;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Hold the button(s) high, release, then allow the operation to finish.
    task automatic press(input logic w, input logic r, input int hold);
        tick(1);
        btn_wr = w;
        btn_rd = r;
        tick(hold);
        btn_wr = 1'b0;
        btn_rd = 1'b0;
        tick(40);
    endtask

    initial begin
        int model_seq;
        int b_wr, b_rd, b_dr, b_busy;
        int hold, got;
        logic w, fl;

        model_seq = 0;
        reset_in = 1'b0;
        btn_wr = 1'b0;
        btn_rd = 1'b0;
        fif.f_full = 1'b0;
        fif.f_empty = 1'b0;
        tick(3);
        check("reset_outputs",
              int'({fif.wr_clk, fif.rd_clk, fif.enable_wr, fif.enable_rd,
                    busy, drop, fif.data_in}), 0);
        reset_in = 1'b1;
        tick(2);

        // Single write, 10-cycle press.
        b_wr = wr_pulses;
        press(1'b1, 1'b0, 10);
        check("wr1_count", wr_pulses - b_wr, 1);
        check("wr1_clk_width", last_wr_hi, 2);
        check("wr1_en_width", last_enw, 5);
        check("wr1_data", last_wr_data, model_seq);
        model_seq = (model_seq + 1) % 8;
        check("wr1_data_after", int'(fif.data_in), model_seq);
        check("wr1_busy_after", int'(busy), 0);

        // Bouncing read button never settles long enough.
        b_rd = rd_pulses;
        b_dr = drops;
        tick(1);
        btn_rd = 1'b1; tick(2);
        btn_rd = 1'b0; tick(2);
        btn_rd = 1'b1; tick(2);
        btn_rd = 1'b0; tick(40);
        check("bounce_rd_count", rd_pulses - b_rd, 0);
        check("bounce_drop", drops - b_dr, 0);

        // Simultaneous presses: write then read.
        b_wr = wr_pulses;
        b_rd = rd_pulses;
        press(1'b1, 1'b1, 12);
        check("sim_wr_count", wr_pulses - b_wr, 1);
        check("sim_rd_count", rd_pulses - b_rd, 1);
        check("sim_wr_data", last_wr_data, model_seq);
        model_seq = (model_seq + 1) % 8;
        check("sim_order", int'(rd_rise_t > wr_rise_t), 1);
        check("sim_gap_short", int'(rd_rise_t - wr_rise_t <= 80), 1);
        check("sim_rd_width", last_rd_hi, 2);
        check("sim_rd_en_width", last_enr, 5);
        check("sim_overlap", overlap, 0);

        // Read while empty is dropped.
        fif.f_empty = 1'b1;
        b_rd = rd_pulses;
        b_dr = drops;
        b_busy = busy_cyc;
        press(1'b0, 1'b1, 10);
        check("empty_drop", drops - b_dr, 1);
        check("empty_rd_count", rd_pulses - b_rd, 0);
        check("empty_busy", busy_cyc - b_busy, 0);
        fif.f_empty = 1'b0;

        // Reset during PULSE_HI of a write.
        tick(1);
        btn_wr = 1'b1;
        got = 0;
        for (int i = 0; i < 40 && got == 0; i++) begin
            @(negedge clk_in);
            if (fif.wr_clk) got = 1;
        end
        check("rst_reach_hi", got, 1);
        #2;
        reset_in = 1'b0;
        #1;
        check("rst_wr_clk", int'(fif.wr_clk), 0);
        check("rst_en_wr", int'(fif.enable_wr), 0);
        check("rst_data", int'(fif.data_in), 0);
        model_seq = 0;
        btn_wr = 1'b0;
        tick(3);
        b_wr = wr_pulses;
        reset_in = 1'b1;
        tick(40);
        check("rst_no_resume", wr_pulses - b_wr, 0);

        // Button held across reset release counts as a new press.
        btn_wr = 1'b1;
        reset_in = 1'b0;
        tick(3);
        b_wr = wr_pulses;
        reset_in = 1'b1;
        tick(12);
        btn_wr = 1'b0;
        tick(40);
        check("held_count", wr_pulses - b_wr, 1);
        check("held_data", last_wr_data, model_seq);
        model_seq = (model_seq + 1) % 8;

        // Sequence wrap after a fresh reset.
        reset_in = 1'b0;
        tick(2);
        reset_in = 1'b1;
        model_seq = 0;
        tick(2);
        for (int k = 0; k < 9; k++) begin
            press(1'b1, 1'b0, 9);
            check("wrap_data", last_wr_data, model_seq);
            model_seq = (model_seq + 1) % 8;
        end

        // Randomized operations against the reference model.
        for (int k = 0; k < 24; k++) begin
            w = 1'($urandom_range(0, 1));
            fl = ($urandom_range(0, 3) == 0);
            hold = $urandom_range(8, 14);
            fif.f_full = w ? fl : 1'b0;
            fif.f_empty = w ? 1'b0 : fl;
            b_wr = wr_pulses;
            b_rd = rd_pulses;
            b_dr = drops;
            press(w, !w, hold);
            check("rnd_wr_count", wr_pulses - b_wr, int'(w && !fl));
            check("rnd_rd_count", rd_pulses - b_rd, int'(!w && !fl));
            check("rnd_drop", drops - b_dr, int'(fl));
            if (w && !fl) begin
                check("rnd_wr_data", last_wr_data, model_seq);
                check("rnd_wr_width", last_wr_hi, 2);
                check("rnd_en_width", last_enw, 5);
                model_seq = (model_seq + 1) % 8;
            end
            if (!w && !fl) begin
                check("rnd_rd_width", last_rd_hi, 2);
                check("rnd_enr_width", last_enr, 5);
            end
            check("rnd_seq", int'(fif.data_in), model_seq);
            check("rnd_busy", int'(busy), 0);
        end

        check("final_overlap", overlap, 0);
        check("final_clk_no_en", bad_clk, 0);
        check("final_data_stable", data_chg, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
